// File: rtl/led_chaser.sv
// LED pattern chaser: free-running step divider, debounced load button,
// and four pattern modes (rotate left/right, bounce, binary count).
module led_chaser #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 21,
  parameter int DB_WIDTH  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_btn_n,
  input  logic [1:0]       i_mode,
  input  logic             i_pause,
  input  logic [WIDTH-1:0] i_seed,
  output logic [WIDTH-1:0] o_led,
  output logic             o_tick
);

  typedef enum logic [1:0] {
    MODE_ROL    = 2'b00,
    MODE_ROR    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_COUNT  = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [WIDTH-1:0] LED_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0] ctr_q, ctr_d;
  logic                 step_en;
  logic                 tick_q, tick_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 btn_db_q, btn_db_d;
  logic [DB_WIDTH-1:0]  db_cnt_q, db_cnt_d;
  logic                 press;
  logic [WIDTH-1:0]     led_q, led_d;
  dir_e                 dir_q, dir_d;
  mode_e                mode;
  logic                 led_zero;

  assign mode     = mode_e'(i_mode);
  assign led_zero = (led_q == '0);

  always_comb begin
    ctr_d   = ctr_q + 1'b1;
    step_en = &ctr_q;
    tick_d  = step_en;
  end

  always_comb begin
    sync1_d = i_btn_n;
    sync2_d = sync1_q;
  end

  // The synced level must disagree with btn_db for 2^DB_WIDTH consecutive
  // clocks before it is accepted; any agreement restarts the window.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    press    = 1'b0;
    if (sync2_q != btn_db_q) begin
      if (&db_cnt_q) begin
        btn_db_d = sync2_q;
        press    = btn_db_q & ~sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    led_d = led_q;
    dir_d = dir_q;
    if (press) begin
      led_d = (i_seed == '0) ? LED_ONE : i_seed;
      dir_d = DIR_LEFT;
    end else if (step_en && !i_pause) begin
      unique case (mode)
        MODE_ROL: begin
          led_d = led_zero ? LED_ONE : {led_q[WIDTH-2:0], led_q[WIDTH-1]};
        end
        MODE_ROR: begin
          led_d = led_zero ? LED_ONE : {led_q[0], led_q[WIDTH-1:1]};
        end
        MODE_BOUNCE: begin
          // Direction flips on the step that finds the lit edge bit, and
          // that same step already moves back inward.
          if (led_zero) begin
            led_d = LED_ONE;
          end else if (dir_q == DIR_LEFT) begin
            if (led_q[WIDTH-1]) begin
              dir_d = DIR_RIGHT;
              led_d = led_q >> 1;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              dir_d = DIR_LEFT;
              led_d = led_q << 1;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
        MODE_COUNT: begin
          led_d = led_q + 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ctr_q    <= '0;
      tick_q   <= 1'b0;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      btn_db_q <= 1'b1;
      db_cnt_q <= '0;
      led_q    <= LED_ONE;
      dir_q    <= DIR_LEFT;
    end else begin
      ctr_q    <= ctr_d;
      tick_q   <= tick_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      btn_db_q <= btn_db_d;
      db_cnt_q <= db_cnt_d;
      led_q    <= led_d;
      dir_q    <= dir_d;
    end
  end

  assign o_led  = led_q;
  assign o_tick = tick_q;

endmodule

// File: doc/led_chaser.md
LED_CHASER -- requirements
Module: led_chaser

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of LED outputs, minimum 2.
REQ-002 SHALL have parameter DIV_WIDTH, default 21: step period is 2^DIV_WIDTH clocks.
REQ-003 SHALL have parameter DB_WIDTH, default 16: button debounce window is 2^DB_WIDTH clocks.
REQ-004 SHALL have port i_clk, input, 1: single clock, all logic on rising edge.
REQ-005 SHALL have port i_rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port i_btn_n, input, 1: raw load button, active-low, asynchronous to i_clk.
REQ-007 SHALL have port i_mode, input, 2: 00 rotate-left, 01 rotate-right, 10 bounce, 11 binary count-up.
REQ-008 SHALL have port i_pause, input, 1: high suppresses pattern steps.
REQ-009 SHALL have port i_seed, input, WIDTH: pattern loaded on button press.
REQ-010 SHALL have port o_led, output, WIDTH: registered LED pattern.
REQ-011 SHALL have port o_tick, output, 1: registered one-cycle pulse per period.

Function
REQ-012 SHALL keep a DIV_WIDTH-bit free-running counter ctr that increments every clock and wraps to 0 after all-ones.
REQ-013 SHALL assert internal step_en combinationally when ctr is all-ones, so that step_en occurs once every 2^DIV_WIDTH clocks.
REQ-014 SHALL drive o_tick as step_en registered, so o_tick is high for exactly the one cycle after each step_en edge, independent of i_pause and i_mode.
REQ-015 SHALL synchronise i_btn_n through two flip-flops before any use.
REQ-016 SHALL hold a debounced state btn_db and a DB_WIDTH-bit counter: the counter clears when the synced value equals btn_db, increments otherwise, and on the edge where it is all-ones with the synced value still different, btn_db takes the synced value and the counter clears.
REQ-017 SHALL treat btn_db going 1->0 as a press; o_led SHALL load on that same edge.
REQ-018 Press load SHALL set o_led to i_seed, or to 1 (LSB only) if i_seed is zero, and SHALL set bounce direction to left.
REQ-019 Press load SHALL take priority over a step in the same cycle, and SHALL act even while i_pause is high.
REQ-020 On step_en with i_pause low and no press, o_led SHALL update per i_mode sampled in that cycle; a mode change SHALL take effect at the next step only.
REQ-021 Rotate-left: o_led <= {o_led[WIDTH-2:0], o_led[WIDTH-1]}.
REQ-022 Rotate-right: o_led <= {o_led[0], o_led[WIDTH-1:1]}.
REQ-023 Bounce with direction left: if o_led[WIDTH-1] is set, direction becomes right and o_led <= o_led >> 1; otherwise o_led <= o_led << 1.
REQ-024 Bounce with direction right: if o_led[0] is set, direction becomes left and o_led <= o_led << 1; otherwise o_led <= o_led >> 1; shifts are zero-filling, and bits pushed off an edge are lost.
REQ-025 Count-up: o_led <= o_led + 1 modulo 2^WIDTH; all-ones wraps to zero.
REQ-026 In rotate and bounce modes, a step with o_led equal to zero SHALL load 1 instead of shifting; count mode SHALL step from zero normally.
REQ-027 The bounce direction register SHALL hold its value while i_mode is not bounce.

Reset
REQ-028 While i_rst is high, the block SHALL asynchronously force: o_led=1, o_tick=0, ctr=0, direction=left, both sync flops=1, btn_db=1, debounce counter=0.
REQ-029 After i_rst falls, the first step_en SHALL occur on clock edge 2^DIV_WIDTH; reset asserted mid-period or mid-debounce SHALL discard all progress.

Verification (WIDTH=8, DIV_WIDTH=3, DB_WIDTH=2)
REQ-030 Rotate-left from reset: o_led 0x01, then 0x02, 0x04, ..., 0x80, 0x01 on successive steps 8 clocks apart; o_tick is high one cycle after each step.
REQ-031 Bounce from reset: o_led 0x01, 0x02, ..., 0x80, 0x40, ..., 0x01, 0x02; direction flips exactly at 0x80 and 0x01.
REQ-032 Count mode with seed 0xFE loaded: o_led 0xFE, 0xFF, 0x00, 0x01.
REQ-033 i_btn_n low for 3 clocks then high: no load. Low held: o_led becomes i_seed=0xA5 at 2 sync + 4 debounce clocks after the fall; seed 0x00 loads 0x01.
REQ-034 i_pause high for 3 periods: o_led frozen and o_tick still pulses. Press coincident with step_en: o_led equals seed, not the stepped value.
REQ-035 i_rst pulsed mid-pattern at o_led=0x10: o_led reads 0x01 immediately, with no clock edge required, and the first step comes 8 clocks after release.
